// File: rtl/mult_div_seq.sv
// Sequential multiply/divide unit: one shift-add (multiply) or
// restoring-subtract (divide) step per clock, start/busy/done handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_IDLE   | waiting for start; operands and signs latched on accept
//   S_RUN    | one iteration per clock, counter 0..WIDTH-1
//   S_FINISH | sign correction, hi/lo write-back, done (and zero-divide)
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_q;
    // Multiplicand for MULT/MULTU, divisor magnitude for DIV/DIVU.
    logic [WIDTH-1:0]   opnd;
    // Multiply: {upper, lower} accumulator. Divide: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes, per-iteration adder/subtractor, and final sign fix-up.
    always_comb begin
        signed_op = ~op[0];
        mag_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        // Remainder shifted left by one can need WIDTH+1 bits before the trial subtract.
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        prod_fix  = neg_res ? (~acc + 1'b1) : acc;
        quo_fix   = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            dz_q        <= 1'b0;
            opnd        <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem <= signed_op && a[WIDTH-1];
                        count   <= '0;
                        busy    <= 1'b1;
                        if (op[1]) begin
                            opnd <= mag_b;
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                        end else begin
                            opnd <= mag_a;
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                        end
                        if (op[1] && (b == '0)) begin
                            dz_q  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            dz_q  <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        if (!div_trial[WIDTH])
                            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        else
                            acc <= {1'b0, acc[2*WIDTH-1:1]};
                    end
                    count <= count + 1'b1;
                    if (count == LAST)
                        state <= S_FINISH;
                end
                S_FINISH: begin
                    // A zero divide leaves hi/lo holding the previous result.
                    if (!dz_q) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    div_by_zero <= dz_q;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    count       <= '0;
                    state       <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: table vectors, random ops against an
// arithmetic reference model, and hand-written busy-start / reset-abort runs.
module tb_mult_div_seq;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    mult_div_seq #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32), .div_by_zero(dz32)
    );

    mult_div_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_by_zero(dz8)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    task automatic ref_model(input int w, input logic [1:0] op, input logic [31:0] a, b,
                             input logic [31:0] phi, plo,
                             output logic [31:0] ehi, elo, output logic edz);
        longint unsigned mask, ua, ub, res_u;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        sa = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        ehi = phi; elo = plo; edz = 1'b0;
        case (op)
            2'b00: begin
                res_u = sa * sb;
                ehi = 32'((res_u >> w) & mask);
                elo = 32'(res_u & mask);
            end
            2'b01: begin
                res_u = ua * ub;
                ehi = 32'((res_u >> w) & mask);
                elo = 32'(res_u & mask);
            end
            2'b10: begin
                if (ub == 0) edz = 1'b1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    elo = 32'(q & mask);
                    ehi = 32'(r & mask);
                end
            end
            default: begin
                if (ub == 0) edz = 1'b1;
                else begin
                    elo = 32'((ua / ub) & mask);
                    ehi = 32'((ua % ub) & mask);
                end
            end
        endcase
    endtask

    task automatic drive(input bit w8, input logic s, input logic [1:0] o, input logic [31:0] x, y);
        if (w8) begin
            start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start32 = s; op32 = o; a32 = x; b32 = y;
        end
    endtask

    task automatic sample(input bit w8, output logic [31:0] h, l, output logic bz, dn, dz);
        if (w8) begin
            h = {24'b0, hi8}; l = {24'b0, lo8}; bz = busy8; dn = done8; dz = dz8;
        end else begin
            h = hi32; l = lo32; bz = busy32; dn = done32; dz = dz32;
        end
    endtask

    // Issue one op; lat = edges from the start edge to the done sample (-1 on timeout).
    // extra_at >= 0 raises start again while busy, after that many edges.
    task automatic run_op(input bit w8, input logic [1:0] op, input logic [31:0] a, b,
                          input int extra_at,
                          output logic [31:0] rhi, rlo, output logic rdz,
                          output int lat, output int bcnt, output bit overlap);
        logic [31:0] h, l;
        logic bz, dn, dz;
        bit got;
        got = 0; lat = 0; bcnt = 0; overlap = 0; rhi = '0; rlo = '0; rdz = 1'b0;
        @(negedge clock);
        drive(w8, 1'b1, op, a, b);
        @(posedge clock); #1;
        drive(w8, 1'b0, 2'($urandom), $urandom, $urandom);
        for (int i = 0; i < 200; i++) begin
            sample(w8, h, l, bz, dn, dz);
            if (bz && dn) overlap = 1;
            if (dn) begin
                got = 1; rhi = h; rlo = l; rdz = dz;
                break;
            end
            if (bz) bcnt++;
            drive(w8, (i == extra_at), 2'($urandom), $urandom, $urandom);
            @(posedge clock); #1;
            lat++;
        end
        drive(w8, 1'b0, 2'b00, 32'd0, 32'd0);
        if (!got) lat = -1;
    endtask

    task automatic count_dones(input bit w8, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (w8 ? done8 : done32) cnt++;
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t tab[10];

    initial begin
        logic [31:0] rhi, rlo, ehi, elo, mhi, mlo;
        logic rdz, edz;
        int lat, bcnt, cnt, elat;
        bit ov;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        tab[0] = '{2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
        tab[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        tab[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};
        tab[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        tab[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        tab[5] = '{2'b01, 32'h00000022, 32'h80000001, 32'h00000011, 32'h00000022, 1'b0, 33};
        tab[6] = '{2'b11, 32'd100,      32'd0,        32'h00000011, 32'h00000022, 1'b1, 1};
        tab[7] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        tab[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
        tab[9] = '{2'b10, 32'd5,        32'd0,        32'd1,        32'hFFFFFFFD, 1'b1, 1};

        reset = 1'b1;
        drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
        drive(1, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst hi", hi32, 0);
        check("rst lo", lo32, 0);
        check("rst busy", busy32, 0);
        check("rst done", done32, 0);
        check("rst dz", dz32, 0);

        foreach (tab[i]) begin
            run_op(0, tab[i].op, tab[i].a, tab[i].b, -1, rhi, rlo, rdz, lat, bcnt, ov);
            check($sformatf("vec%0d hi", i), rhi, tab[i].hi);
            check($sformatf("vec%0d lo", i), rlo, tab[i].lo);
            check($sformatf("vec%0d dz", i), rdz, tab[i].dz);
            check($sformatf("vec%0d latency", i), lat, tab[i].lat);
            check($sformatf("vec%0d busy cycles", i), bcnt, tab[i].lat);
            check($sformatf("vec%0d busy&done", i), ov, 0);
        end
        mhi = tab[9].hi; mlo = tab[9].lo;

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'd1;
                default: rb = $urandom;
            endcase
            ref_model(32, rop, ra, rb, mhi, mlo, ehi, elo, edz);
            elat = (rop[1] && rb == 0) ? 1 : 33;
            run_op(0, rop, ra, rb, -1, rhi, rlo, rdz, lat, bcnt, ov);
            check($sformatf("rnd%0d hi", i), rhi, ehi);
            check($sformatf("rnd%0d lo", i), rlo, elo);
            check($sformatf("rnd%0d dz", i), rdz, edz);
            check($sformatf("rnd%0d latency", i), lat, elat);
            check($sformatf("rnd%0d busy&done", i), ov, 0);
            mhi = ehi; mlo = elo;
        end

        // Second start while running is dropped.
        ref_model(32, 2'b00, 32'd1234, 32'hFFFFFFFB, mhi, mlo, ehi, elo, edz);
        run_op(0, 2'b00, 32'd1234, 32'hFFFFFFFB, 10, rhi, rlo, rdz, lat, bcnt, ov);
        check("busy-start hi", rhi, ehi);
        check("busy-start lo", rlo, elo);
        check("busy-start latency", lat, 33);
        count_dones(0, 45, cnt);
        check("busy-start extra done", cnt, 0);
        check("busy-start hi held", hi32, ehi);

        // Reset in the middle of a divide.
        @(negedge clock);
        drive(0, 1'b1, 2'b10, 32'd1000, 32'd7);
        @(posedge clock); #1;
        drive(0, 1'b0, 2'b00, 32'd0, 32'd0);
        repeat (15) @(posedge clock);
        #2;
        check("abort busy before", busy32, 1);
        reset = 1'b1;
        #1;
        check("abort hi", hi32, 0);
        check("abort lo", lo32, 0);
        check("abort busy", busy32, 0);
        check("abort done", done32, 0);
        check("abort dz", dz32, 0);
        @(negedge clock);
        reset = 1'b0;
        count_dones(0, 40, cnt);
        check("abort no done", cnt, 0);
        run_op(0, 2'b11, 32'd1000, 32'd7, -1, rhi, rlo, rdz, lat, bcnt, ov);
        check("after abort hi", rhi, 6);
        check("after abort lo", rlo, 142);
        check("after abort latency", lat, 33);

        // WIDTH=8 instance.
        run_op(1, 2'b00, 32'h80, 32'h80, -1, rhi, rlo, rdz, lat, bcnt, ov);
        check("w8 mult hi", rhi, 32'h40);
        check("w8 mult lo", rlo, 32'h00);
        check("w8 mult latency", lat, 9);
        check("w8 mult busy cycles", bcnt, 9);
        mhi = 32'h40; mlo = 32'h00;
        for (int i = 0; i < 25; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 255));
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            ref_model(8, rop, ra, rb, mhi, mlo, ehi, elo, edz);
            elat = (rop[1] && rb == 0) ? 1 : 9;
            run_op(1, rop, ra, rb, -1, rhi, rlo, rdz, lat, bcnt, ov);
            check($sformatf("w8 rnd%0d hi", i), rhi, ehi);
            check($sformatf("w8 rnd%0d lo", i), rlo, elo);
            check($sformatf("w8 rnd%0d dz", i), rdz, edz);
            check($sformatf("w8 rnd%0d latency", i), lat, elat);
            mhi = ehi; mlo = elo;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
